// File: rtl/hzd_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath drives the master side; hzd_ctrl sits on the slave side.
interface hzd_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           i_rs1_idx;
  logic [4:0]           i_rs2_idx;
  logic                 i_rs1_en;
  logic                 i_rs2_en;
  logic [4:0]           i_rdidx_e;
  logic                 i_rd_en_e;
  logic                 i_is_load_e;
  logic [4:0]           i_rs1idx_e;
  logic [4:0]           i_rs2idx_e;
  logic [4:0]           i_rdidx_m;
  logic                 i_rd_en_m;
  logic [4:0]           i_rdidx_w;
  logic                 i_rd_en_w;
  logic                 i_ex_redirect;
  logic                 i_mem_busy;
  logic                 o_if2id_stall;
  logic                 o_if2id_flush;
  logic                 o_id2ex_stall;
  logic                 o_id2ex_flush;
  logic                 o_ex2mem_stall;
  logic [1:0]           o_fwd_rs1_sel;
  logic [1:0]           o_fwd_rs2_sel;
  logic                 o_mem_timeout;
  logic [CNT_WIDTH-1:0] o_stall_cnt;
  logic [1:0]           state_dbg;

  // No valid/ready pairs here: every input is a level sampled in the same
  // cycle, and every control output responds combinationally in that cycle.
  modport master (
    output i_rs1_idx, i_rs2_idx, i_rs1_en, i_rs2_en,
           i_rdidx_e, i_rd_en_e, i_is_load_e, i_rs1idx_e, i_rs2idx_e,
           i_rdidx_m, i_rd_en_m, i_rdidx_w, i_rd_en_w,
           i_ex_redirect, i_mem_busy,
    input  o_if2id_stall, o_if2id_flush, o_id2ex_stall, o_id2ex_flush,
           o_ex2mem_stall, o_fwd_rs1_sel, o_fwd_rs2_sel,
           o_mem_timeout, o_stall_cnt, state_dbg
  );

  modport slave (
    input  i_rs1_idx, i_rs2_idx, i_rs1_en, i_rs2_en,
           i_rdidx_e, i_rd_en_e, i_is_load_e, i_rs1idx_e, i_rs2idx_e,
           i_rdidx_m, i_rd_en_m, i_rdidx_w, i_rd_en_w,
           i_ex_redirect, i_mem_busy,
    output o_if2id_stall, o_if2id_flush, o_id2ex_stall, o_id2ex_flush,
           o_ex2mem_stall, o_fwd_rs1_sel, o_fwd_rs2_sel,
           o_mem_timeout, o_stall_cnt, state_dbg
  );
endinterface

// File: rtl/hzd_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, data-memory
// wait states, branch/jump redirects, and EX-stage forwarding selects.
module hzd_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  hzd_ctrl_if.slave    hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_MEMW  = 2'd2
  } state_t;

  localparam int             WC_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

  state_t               state, state_nxt;
  logic                 pending_redir, pending_nxt;
  logic [WC_W-1:0]      wait_cnt, wait_nxt;
  logic                 mem_timeout, timeout_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  logic lu;
  logic if_stall_raw, if_flush_raw, id_stall_raw, id_flush_raw, ex_stall_raw;
  logic if_stall, if_flush, id_stall, id_flush, ex_stall;
  logic any_stall;

  assign lu = hz.i_is_load_e & hz.i_rd_en_e & (hz.i_rdidx_e != 5'd0) &
              ((hz.i_rs1_en & (hz.i_rs1_idx == hz.i_rdidx_e)) |
               (hz.i_rs2_en & (hz.i_rs2_idx == hz.i_rdidx_e)));

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state         <= ST_RUN;
      pending_redir <= 1'b0;
      wait_cnt      <= '0;
      mem_timeout   <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      pending_redir <= pending_nxt;
      wait_cnt      <= wait_nxt;
      mem_timeout   <= timeout_nxt;
      if (any_stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending_redir;
    wait_nxt     = wait_cnt;
    if_stall_raw = 1'b0;
    if_flush_raw = 1'b0;
    id_stall_raw = 1'b0;
    id_flush_raw = 1'b0;
    ex_stall_raw = 1'b0;
    case (state)
      // LDUSE evaluates exactly like RUN; it only differs in where it goes next.
      ST_RUN, ST_LDUSE: begin
        state_nxt = ST_RUN;
        if (hz.i_mem_busy) begin
          if_stall_raw = 1'b1;
          id_stall_raw = 1'b1;
          ex_stall_raw = 1'b1;
          state_nxt    = ST_MEMW;
          if (hz.i_ex_redirect) pending_nxt = 1'b1;
        end else if (hz.i_ex_redirect) begin
          if_flush_raw = 1'b1;
          id_flush_raw = 1'b1;
        end else if (lu) begin
          if_stall_raw = 1'b1;
          id_flush_raw = 1'b1;
          if (state == ST_RUN) state_nxt = ST_LDUSE;
        end
      end
      ST_MEMW: begin
        if (hz.i_mem_busy) begin
          if_stall_raw = 1'b1;
          id_stall_raw = 1'b1;
          ex_stall_raw = 1'b1;
          if (hz.i_ex_redirect) pending_nxt = 1'b1;
          if (wait_cnt != WC_MAX) wait_nxt = wait_cnt + 1'b1;
        end else begin
          // A redirect landing on the release cycle is honoured immediately.
          if (pending_redir | hz.i_ex_redirect) begin
            if_flush_raw = 1'b1;
            id_flush_raw = 1'b1;
          end
          pending_nxt = 1'b0;
          wait_nxt    = '0;
          state_nxt   = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    timeout_nxt = mem_timeout |
                  ((state == ST_MEMW) & hz.i_mem_busy & (wait_nxt == WC_MAX));
  end

  // Flush beats stall on the same register; everything is held low in reset.
  assign if_flush  = if_flush_raw & rst_sys;
  assign id_flush  = id_flush_raw & rst_sys;
  assign if_stall  = if_stall_raw & ~if_flush_raw & rst_sys;
  assign id_stall  = id_stall_raw & ~id_flush_raw & rst_sys;
  assign ex_stall  = ex_stall_raw & rst_sys;
  assign any_stall = if_stall | id_stall | ex_stall;

  always_comb begin
    hz.o_fwd_rs1_sel = 2'b00;
    hz.o_fwd_rs2_sel = 2'b00;
    if (hz.i_rs1idx_e != 5'd0) begin
      if (hz.i_rd_en_m && hz.i_rdidx_m == hz.i_rs1idx_e)      hz.o_fwd_rs1_sel = 2'b01;
      else if (hz.i_rd_en_w && hz.i_rdidx_w == hz.i_rs1idx_e) hz.o_fwd_rs1_sel = 2'b10;
    end
    if (hz.i_rs2idx_e != 5'd0) begin
      if (hz.i_rd_en_m && hz.i_rdidx_m == hz.i_rs2idx_e)      hz.o_fwd_rs2_sel = 2'b01;
      else if (hz.i_rd_en_w && hz.i_rdidx_w == hz.i_rs2idx_e) hz.o_fwd_rs2_sel = 2'b10;
    end
  end

  assign hz.o_if2id_stall  = if_stall;
  assign hz.o_if2id_flush  = if_flush;
  assign hz.o_id2ex_stall  = id_stall;
  assign hz.o_id2ex_flush  = id_flush;
  assign hz.o_ex2mem_stall = ex_stall;
  assign hz.o_mem_timeout  = mem_timeout;
  assign hz.o_stall_cnt    = stall_cnt;
  assign hz.state_dbg      = state;

endmodule
